score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper.sv | 198 +++++++++++++++++++
 tb/tb_score_keeper.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Score keeper for a two-player ball game.
//
// Counts misses reported once per video frame, applies a post-point holdoff,
// detects the winning score and drives a 4-digit multiplexed 7-segment display.
//
// Ports
//   clk50M      in   system clock
//   reset_n     in   asynchronous active-low reset
//   endofframe  in   frame level from graphics; rising edge is the frame tick
//   missed      in   ball touched a border (sampled on the frame tick)
//   ball_x      in   ball left edge; < 320 means player two scores
//   new_game    in   raw asynchronous push button
//   score_one   out  player one score
//   score_two   out  player two score
//   game_over   out  high while the game is finished
//   winner      out  0 = player one, 1 = player two (valid with game_over)
//   serve       out  one-cycle ball re-serve request
//   seg         out  active-low segments, seg[6]=g .. seg[0]=a
//   an          out  active-low digit anodes
module score_keeper #(
   parameter int unsigned WIN_SCORE      = 9,
   parameter int unsigned HOLDOFF_FRAMES = 30,
   parameter int unsigned REFRESH_DIV    = 50000
) (
   input  logic       clk50M,
   input  logic       reset_n,
   input  logic       endofframe,
   input  logic       missed,
   input  logic [9:0] ball_x,
   input  logic       new_game,
   output logic [3:0] score_one,
   output logic [3:0] score_two,
   output logic       game_over,
   output logic       winner,
   output logic       serve,
   output logic [6:0] seg,
   output logic [3:0] an
);

   localparam int unsigned HoldW = (HOLDOFF_FRAMES > 1) ? $clog2(HOLDOFF_FRAMES) : 1;
   localparam int unsigned RefW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLDOFF_FRAMES - 1);
   localparam logic [RefW-1:0]  RefLast  = RefW'(REFRESH_DIV - 1);
   localparam logic [3:0]       WinVal   = 4'(WIN_SCORE);

   typedef enum logic [1:0] {StPlay, StHoldoff, StGameOver} state_e;

   // Input conditioning
   logic eof_q;
   logic ng_meta_q, ng_sync_q, ng_prev_q;
   logic tick, ng_pulse;

   always_ff @(posedge clk50M or negedge reset_n) begin
      if (!reset_n) begin
         eof_q     <= 1'b0;
         ng_meta_q <= 1'b0;
         ng_sync_q <= 1'b0;
         ng_prev_q <= 1'b0;
      end else begin
         eof_q     <= endofframe;
         ng_meta_q <= new_game;
         ng_sync_q <= ng_meta_q;
         ng_prev_q <= ng_sync_q;
      end
   end

   assign tick     = endofframe & ~eof_q;
   assign ng_pulse = ng_sync_q & ~ng_prev_q;

   // Game FSM
   state_e           state_q;
   logic [3:0]       score_one_q, score_two_q;
   logic             game_over_q, winner_q, serve_q;
   logic [HoldW-1:0] hold_q;

   logic       scorer_two;
   logic [3:0] cur_score, new_score;

   always_comb begin
      scorer_two = (ball_x < 10'd320);
      cur_score  = scorer_two ? score_two_q : score_one_q;
      // Saturate so a score can never pass the winning value
      new_score  = (cur_score >= WinVal) ? WinVal : cur_score + 4'd1;
   end

   always_ff @(posedge clk50M or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StPlay;
         score_one_q <= 4'd0;
         score_two_q <= 4'd0;
         game_over_q <= 1'b0;
         winner_q    <= 1'b0;
         serve_q     <= 1'b0;
         hold_q      <= '0;
      end else begin
         serve_q <= 1'b0;
         // New game wins over a coincident scoring tick
         if (ng_pulse) begin
            state_q     <= StPlay;
            score_one_q <= 4'd0;
            score_two_q <= 4'd0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            serve_q     <= 1'b1;
            hold_q      <= '0;
         end else if (tick) begin
            case (state_q)
               StPlay: begin
                  if (missed) begin
                     if (scorer_two) score_two_q <= new_score;
                     else            score_one_q <= new_score;
                     if (new_score == WinVal) begin
                        state_q     <= StGameOver;
                        game_over_q <= 1'b1;
                        winner_q    <= scorer_two;
                     end else begin
                        state_q <= StHoldoff;
                        hold_q  <= HoldLoad;
                     end
                  end
               end
               StHoldoff: begin
                  if (hold_q == '0) begin
                     state_q <= StPlay;
                     serve_q <= 1'b1;
                  end else begin
                     hold_q <= hold_q - 1'b1;
                  end
               end
               StGameOver: ;
               default: state_q <= StPlay;
            endcase
         end
      end
   end

   assign score_one = score_one_q;
   assign score_two = score_two_q;
   assign game_over = game_over_q;
   assign winner    = winner_q;
   assign serve     = serve_q;

   // Display multiplexing
   logic [RefW-1:0] ref_q, ref_d;
   logic [1:0]      idx_q, idx_d;
   logic [6:0]      seg_q, seg_d;
   logic [3:0]      an_q, an_d;

   function automatic logic [6:0] enc(input logic [3:0] v);
      case (v)
         4'd0:    enc = 7'b1000000;
         4'd1:    enc = 7'b1111001;
         4'd2:    enc = 7'b0100100;
         4'd3:    enc = 7'b0110000;
         4'd4:    enc = 7'b0011001;
         4'd5:    enc = 7'b0010010;
         4'd6:    enc = 7'b0000010;
         4'd7:    enc = 7'b1111000;
         4'd8:    enc = 7'b0000000;
         4'd9:    enc = 7'b0010000;
         default: enc = 7'b1111111;
      endcase
   endfunction

   always_comb begin
      ref_d = ref_q + 1'b1;
      idx_d = idx_q;
      if (ref_q == RefLast) begin
         ref_d = '0;
         idx_d = idx_q + 2'd1;
      end
      // Decode from the next index so seg and an update on the same edge
      an_d = ~(4'b0001 << idx_d);
      case (idx_d)
         2'd3:    seg_d = enc(score_one_q);
         2'd0:    seg_d = enc(score_two_q);
         default: seg_d = game_over_q ? 7'b0111111 : 7'b1111111;
      endcase
   end

   always_ff @(posedge clk50M or negedge reset_n) begin
      if (!reset_n) begin
         ref_q <= '0;
         idx_q <= 2'd0;
         seg_q <= 7'b1000000;
         an_q  <= 4'b1110;
      end else begin
         ref_q <= ref_d;
         idx_q <= idx_d;
         seg_q <= seg_d;
         an_q  <= an_d;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

   localparam int unsigned WIN  = 9;
   localparam int unsigned HOLD = 30;
   localparam int unsigned DIV  = 16;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       endofframe = 1'b0;
   logic       missed = 1'b0;
   logic [9:0] ball_x = '0;
   logic       new_game = 1'b0;
   logic [3:0] score_one, score_two;
   logic       game_over, winner, serve;
   logic [6:0] seg;
   logic [3:0] an;

   score_keeper #(
      .WIN_SCORE      (WIN),
      .HOLDOFF_FRAMES (HOLD),
      .REFRESH_DIV    (DIV)
   ) dut (
      .clk50M     (clk),
      .reset_n    (reset_n),
      .endofframe (endofframe),
      .missed     (missed),
      .ball_x     (ball_x),
      .new_game   (new_game),
      .score_one  (score_one),
      .score_two  (score_two),
      .game_over  (game_over),
      .winner     (winner),
      .serve      (serve),
      .seg        (seg),
      .an         (an)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int serve_seen = 0;

   always @(negedge clk) if (serve === 1'b1) serve_seen++;

   // Reference model, tracked per frame tick
   int m_s1 = 0, m_s2 = 0, m_hold = 0, m_serves = 0;
   bit m_over = 0, m_win = 0;

   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_tick(input bit m, input int x);
      if (m_over) return;
      if (m_hold > 0) begin
         m_hold--;
         if (m_hold == 0) m_serves++;
         return;
      end
      if (m) begin
         if (x < 320) m_s2++;
         else         m_s1++;
         if (m_s1 == WIN || m_s2 == WIN) begin
            m_over = 1;
            m_win  = (m_s2 == WIN);
         end else begin
            m_hold = HOLD;
         end
      end
   endtask

   task automatic model_new_game();
      m_s1 = 0; m_s2 = 0; m_hold = 0; m_over = 0; m_win = 0;
      m_serves++;
   endtask

   task automatic check_all(input string tag);
      chk({tag, "/score_one"}, 32'(score_one), 32'(m_s1));
      chk({tag, "/score_two"}, 32'(score_two), 32'(m_s2));
      chk({tag, "/game_over"}, 32'(game_over), 32'(m_over));
      if (m_over) chk({tag, "/winner"}, 32'(winner), 32'(m_win));
      chk({tag, "/serves"}, 32'(serve_seen), 32'(m_serves));
   endtask

   task automatic do_tick(input bit m, input int x);
      @(negedge clk);
      missed = m; ball_x = 10'(x); endofframe = 1'b1;
      @(negedge clk);
      endofframe = 1'b0; missed = 1'b0;
      repeat (2) @(negedge clk);
      model_tick(m, x);
   endtask

   task automatic quiet_ticks(input int n);
      for (int i = 0; i < n; i++) do_tick(1'b0, 0);
   endtask

   task automatic press_ng(input int cycles);
      @(negedge clk);
      new_game = 1'b1;
      repeat (cycles) @(negedge clk);
      new_game = 1'b0;
      repeat (4) @(negedge clk);
      model_new_game();
   endtask

   task automatic wait_an(input logic [3:0] want, input string tag);
      int n = 0;
      while (an !== want && n < 5 * DIV) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "/an_reach"}, 32'(an), 32'(want));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "/score_one"}, 32'(score_one), 32'd0);
      chk({tag, "/score_two"}, 32'(score_two), 32'd0);
      chk({tag, "/game_over"}, 32'(game_over), 32'd0);
      chk({tag, "/winner"}, 32'(winner), 32'd0);
      chk({tag, "/serve"}, 32'(serve), 32'd0);
      chk({tag, "/an"}, 32'(an), 32'(4'b1110));
      chk({tag, "/seg"}, 32'(seg), 32'(7'b1000000));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] exp_an;
      int s0;

      // Reset values
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");

      // Release and check digit scan order
      @(negedge clk);
      #1 reset_n = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         repeat (DIV) @(negedge clk);
         exp_an = 4'b1111;
         exp_an[i % 4] = 1'b0;
         chk($sformatf("scan%0d", i), 32'(an), 32'(exp_an));
      end

      // Idle ticks do nothing
      quiet_ticks(5);
      check_all("idle");
      chk("idle/no_serve", 32'(serve_seen), 32'd0);

      // One miss held for many frames scores once; serve on 30th tick after
      do_tick(1'b1, 5);
      for (int i = 0; i < 10; i++) do_tick(1'b1, 5);
      check_all("hold_miss");
      chk("hold_miss/s2", 32'(score_two), 32'd1);
      quiet_ticks(19);
      chk("hold_pre_serve", 32'(serve_seen), 32'd0);
      quiet_ticks(1);
      chk("hold_serve", 32'(serve_seen), 32'd1);
      check_all("hold_end");

      // Side boundary
      do_tick(1'b1, 319);
      quiet_ticks(HOLD);
      do_tick(1'b1, 320);
      quiet_ticks(HOLD);
      check_all("boundary");

      // Player one to 8/0, then the winning point
      press_ng(3);
      check_all("ng1");
      for (int p = 0; p < 8; p++) begin
         do_tick(1'b1, 600);
         quiet_ticks(HOLD);
      end
      check_all("eight");
      do_tick(1'b1, 600);
      check_all("win");
      chk("win/over", 32'(game_over), 32'd1);
      wait_an(4'b1011, "dash2");
      chk("dash2/seg", 32'(seg), 32'(7'b0111111));
      wait_an(4'b1101, "dash1");
      chk("dash1/seg", 32'(seg), 32'(7'b0111111));
      wait_an(4'b0111, "dig3");
      chk("dig3/seg", 32'(seg), 32'(seg_tab[9]));
      wait_an(4'b1110, "dig0");
      chk("dig0/seg", 32'(seg), 32'(seg_tab[0]));
      do_tick(1'b1, 5);
      do_tick(1'b1, 600);
      quiet_ticks(HOLD + 2);
      check_all("frozen");

      // Long button hold gives exactly one new game
      s0 = serve_seen;
      press_ng(500);
      check_all("long_ng");
      chk("long_ng/one_serve", 32'(serve_seen - s0), 32'd1);
      wait_an(4'b1101, "blank1");
      chk("blank1/seg", 32'(seg), 32'(7'b1111111));
      do_tick(1'b1, 5);
      quiet_ticks(HOLD);
      check_all("after_ng_play");

      // New game coincident with a scoring tick
      do_tick(1'b1, 600);
      quiet_ticks(HOLD);
      @(negedge clk);
      new_game = 1'b1;
      @(negedge clk);
      @(negedge clk);
      missed = 1'b1; ball_x = 10'd5; endofframe = 1'b1;
      @(negedge clk);
      endofframe = 1'b0; missed = 1'b0; new_game = 1'b0;
      repeat (4) @(negedge clk);
      model_new_game();
      check_all("coincide");
      quiet_ticks(HOLD + 2);
      check_all("coincide_after");

      // Randomized play
      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(0, 49) == 0) press_ng(int'($urandom_range(1, 6)));
         else do_tick($urandom_range(0, 2) == 0, int'($urandom_range(0, 639)));
         check_all($sformatf("rand%0d", it));
      end

      // Reset pulse during holdoff at 3/2
      press_ng(2);
      for (int p = 0; p < 3; p++) begin
         do_tick(1'b1, 600);
         quiet_ticks(HOLD);
      end
      do_tick(1'b1, 5);
      quiet_ticks(HOLD);
      do_tick(1'b1, 5);
      quiet_ticks(5);
      check_all("pre_reset");
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      @(negedge clk);
      reset_n = 1'b1;
      m_s1 = 0; m_s2 = 0; m_hold = 0; m_over = 0; m_win = 0;
      s0 = serve_seen;
      repeat (3) @(negedge clk);
      chk("post_reset/no_serve", 32'(serve_seen), 32'(s0));
      do_tick(1'b1, 600);
      check_all("post_reset_score");
      chk("post_reset/s1", 32'(score_one), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
